// File: rtl/pow_5_rr_arbiter_if.sv
// Handshake and datapath bundle between two requesters, the arbiter and one pow_5 unit.
// slave: the arbiter's view. master: the surrounding clients and unit.
interface pow_5_rr_arbiter_if #(
    parameter int unsigned w = 8
);
    logic         a_vld;
    logic [w-1:0] a_n;
    logic         a_rdy;
    logic         b_vld;
    logic [w-1:0] b_n;
    logic         b_rdy;
    logic         pow_n_vld;
    logic [w-1:0] pow_n;
    logic         pow_res_vld;
    logic [w-1:0] pow_res;
    logic         a_res_vld;
    logic [w-1:0] a_res;
    logic         b_res_vld;
    logic [w-1:0] b_res;
    logic         err;

    modport slave (
        input  a_vld, a_n, b_vld, b_n, pow_res_vld, pow_res,
        output a_rdy, b_rdy, pow_n_vld, pow_n, a_res_vld, a_res, b_res_vld, b_res, err
    );

    modport master (
        output a_vld, a_n, b_vld, b_n, pow_res_vld, pow_res,
        input  a_rdy, b_rdy, pow_n_vld, pow_n, a_res_vld, a_res, b_res_vld, b_res, err
    );
endinterface

// File: rtl/pow_5_rr_arbiter.sv
// pow_5_rr_arbiter: shares one pipelined pow_5 unit between requesters A and B.
// Grants at most one issue per cycle, tracks the owner of each in-flight operation in a
// tag pipeline matched to the unit latency and routes each result back to its owner.
// Build option: define POW_5_ARB_FIXED_PRIO_EN for fixed priority (A always beats B);
// left undefined, contention is resolved round-robin.
module pow_5_rr_arbiter #(
    parameter int unsigned w   = 8,
    parameter int unsigned LAT = 2   // unit latency pow_n_vld -> pow_res_vld, >= 1
) (
    input logic               clk,
    input logic               rst_n,
    pow_5_rr_arbiter_if.slave bus_io
);
    typedef enum logic {
        IdA = 1'b0,
        IdB = 1'b1
    } req_id_e;

    typedef struct packed {
        logic    vld;
        req_id_e id;
    } tag_t;

    logic    grant_a;
    logic    grant_b;
    logic    grant_any;
    req_id_e grant_id;

`ifdef POW_5_ARB_FIXED_PRIO_EN
    // Fixed priority: B is served only while A is idle.
    always_comb begin
        grant_a = bus_io.a_vld;
        grant_b = bus_io.b_vld & ~bus_io.a_vld;
    end
`else
    req_id_e last_q;
    req_id_e last_d;

    // Round-robin grant: on contention the requester not served last wins.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        last_d  = last_q;
        if (bus_io.a_vld && bus_io.b_vld) begin
            grant_a = (last_q == IdB);
            grant_b = (last_q == IdA);
        end else begin
            grant_a = bus_io.a_vld;
            grant_b = bus_io.b_vld;
        end
        if (grant_a) begin
            last_d = IdA;
        end else if (grant_b) begin
            last_d = IdB;
        end
    end

    // Pointer resets to B so that A wins the first contention.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IdB;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign grant_any    = grant_a | grant_b;
    assign grant_id     = grant_b ? IdB : IdA;
    assign bus_io.a_rdy = grant_a;
    assign bus_io.b_rdy = grant_b;

    // Stage 0 is the issue-stage tag (aligned with pow_n_vld); stage LAT lines up with
    // pow_res_vld.
    logic               pow_n_vld_q;
    logic [w-1:0]       pow_n_q;
    tag_t [LAT:0]       tag_q;
    tag_t               tag_in;
    tag_t               tag_out;

    assign tag_in.vld = grant_any;
    assign tag_in.id  = grant_id;
    assign tag_out    = tag_q[LAT];

    // Issue valid and tag pipeline; reset discards every in-flight tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pow_n_vld_q <= 1'b0;
            tag_q       <= '0;
        end else begin
            pow_n_vld_q <= grant_any;
            tag_q       <= {tag_q[LAT-1:0], tag_in};
        end
    end

    // Issue operand: data only, meaningful while pow_n_vld is high.
    always_ff @(posedge clk) begin
        if (grant_any) begin
            pow_n_q <= grant_b ? bus_io.b_n : bus_io.a_n;
        end
    end

    logic         ret_vld;
    logic         a_res_vld_q;
    logic         b_res_vld_q;
    logic [w-1:0] a_res_q;
    logic [w-1:0] b_res_q;
    logic         err_q;

    // A result without a valid tag is dropped rather than routed.
    assign ret_vld = bus_io.pow_res_vld & tag_out.vld;

    // Return valids and sticky error on any disagreement between unit and tag timing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_res_vld_q <= 1'b0;
            b_res_vld_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            a_res_vld_q <= ret_vld & (tag_out.id == IdA);
            b_res_vld_q <= ret_vld & (tag_out.id == IdB);
            err_q       <= err_q | (bus_io.pow_res_vld != tag_out.vld);
        end
    end

    // Return data: captured only on a valid return to its owner.
    always_ff @(posedge clk) begin
        if (ret_vld) begin
            if (tag_out.id == IdA) begin
                a_res_q <= bus_io.pow_res;
            end else begin
                b_res_q <= bus_io.pow_res;
            end
        end
    end

    assign bus_io.pow_n_vld = pow_n_vld_q;
    assign bus_io.pow_n     = pow_n_q;
    assign bus_io.a_res_vld = a_res_vld_q;
    assign bus_io.a_res     = a_res_q;
    assign bus_io.b_res_vld = b_res_vld_q;
    assign bus_io.b_res     = b_res_q;
    assign bus_io.err       = err_q;
endmodule
